// File: rtl/fifo_pkt_pkg.sv
// Shared definitions for the FIFO packet serializer.
//   state_e           : serializer FSM states
//   DEFAULT_SYNC_BYTE : first byte of every packet unless overridden
//   bytes_per_word()  : number of bytes a FIFO word is split into
package fifo_pkt_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_SEQ   = 3'd2,
    ST_FETCH = 3'd3,
    ST_LATCH = 3'd4,
    ST_SEND  = 3'd5
  } state_e;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  // DATA_WIDTH is expected to be a multiple of 8.
  function automatic int unsigned bytes_per_word(input int unsigned data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/fifo_pkt_serializer.sv
// Read-side consumer of the sample FIFO. Pops words and frames them as
//   SYNC_BYTE, pkt_seq, WORDS_PER_PKT words (MSB byte first)
// onto an 8-bit valid/ready byte stream.
//
// Ports:
//   clk, rst        : read-domain clock, synchronous active-high reset
//   fifo_rd_en      : pop request (combinational, only in FETCH when not empty)
//   fifo_rd_empty   : FIFO empty flag
//   fifo_rd_data    : FIFO data, valid the cycle after an accepted pop
//   tx_data/tx_valid: registered byte stream toward the transmitter
//   tx_ready        : transmitter accepts the byte
//   pkt_seq         : sequence number of the packet being / next to be sent
//   busy            : high whenever the FSM is not IDLE
//
// Handshake: a byte transfers on a cycle where tx_valid && tx_ready. Once
// tx_valid is raised, tx_valid and tx_data stay unchanged until that
// transfer; tx_ready is ignored while tx_valid is low.
//
// The FSM state is held in state_q and can be probed hierarchically.
module fifo_pkt_serializer
  import fifo_pkt_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 24,
  parameter int unsigned WORDS_PER_PKT = 16,
  parameter logic [7:0]  SYNC_BYTE     = DEFAULT_SYNC_BYTE
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  fifo_rd_en,
  input  logic                  fifo_rd_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [7:0]            pkt_seq,
  output logic                  busy
);

  localparam int unsigned BPW = bytes_per_word(DATA_WIDTH);
  localparam int unsigned BCW = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int unsigned WCW = (WORDS_PER_PKT > 1) ? $clog2(WORDS_PER_PKT) : 1;
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(BPW - 1);
  localparam logic [WCW-1:0] LAST_WORD = WCW'(WORDS_PER_PKT - 1);

  state_e                state_q, state_d;
  logic                  tx_valid_q, tx_valid_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic [7:0]            pkt_seq_q, pkt_seq_d;
  logic [WCW-1:0]        word_cnt_q, word_cnt_d;
  logic [BCW-1:0]        byte_cnt_q, byte_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] nxt_shift;
  logic                  handshake;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
      pkt_seq_q  <= 8'h00;
      word_cnt_q <= '0;
      byte_cnt_q <= '0;
      shift_q    <= '0;
    end else begin
      state_q    <= state_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      pkt_seq_q  <= pkt_seq_d;
      word_cnt_q <= word_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    pkt_seq_d  = pkt_seq_q;
    word_cnt_d = word_cnt_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    fifo_rd_en = 1'b0;
    handshake  = tx_valid_q && tx_ready;
    nxt_shift  = shift_q << 8;

    case (state_q)
      ST_IDLE: begin
        // The header is only started once a word is actually available.
        if (!fifo_rd_empty) begin
          state_d    = ST_HDR;
          tx_valid_d = 1'b1;
          tx_data_d  = SYNC_BYTE;
        end
      end

      ST_HDR: begin
        if (handshake) begin
          state_d   = ST_SEQ;
          tx_data_d = pkt_seq_q;
        end
      end

      ST_SEQ: begin
        if (handshake) begin
          state_d    = ST_FETCH;
          tx_valid_d = 1'b0;
        end
      end

      ST_FETCH: begin
        // Mid-packet underflow just waits here; the packet is never aborted.
        if (!fifo_rd_empty) begin
          fifo_rd_en = 1'b1;
          state_d    = ST_LATCH;
        end
      end

      ST_LATCH: begin
        // Popped data is on fifo_rd_data this cycle; present its MSB byte
        // directly so SEND starts with a valid byte.
        shift_d    = fifo_rd_data;
        byte_cnt_d = '0;
        tx_valid_d = 1'b1;
        tx_data_d  = fifo_rd_data[DATA_WIDTH-1 -: 8];
        state_d    = ST_SEND;
      end

      ST_SEND: begin
        if (handshake) begin
          shift_d    = nxt_shift;
          byte_cnt_d = byte_cnt_q + BCW'(1);
          if (byte_cnt_q == LAST_BYTE) begin
            tx_valid_d = 1'b0;
            if (word_cnt_q == LAST_WORD) begin
              word_cnt_d = '0;
              pkt_seq_d  = pkt_seq_q + 8'd1;
              state_d    = ST_IDLE;
            end else begin
              word_cnt_d = word_cnt_q + WCW'(1);
              state_d    = ST_FETCH;
            end
          end else begin
            tx_data_d = nxt_shift[DATA_WIDTH-1 -: 8];
          end
        end
      end

      default: begin
        state_d    = ST_IDLE;
        tx_valid_d = 1'b0;
      end
    endcase
  end

  assign tx_valid = tx_valid_q;
  assign tx_data  = tx_data_q;
  assign pkt_seq  = pkt_seq_q;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fifo_pkt_serializer.sv
// Bench for fifo_pkt_serializer (WORDS_PER_PKT=2, DATA_WIDTH=24).
// The expected byte stream is built from packet framing rules into exp_q;
// a negedge monitor checks every transferred byte plus the handshake and
// pop rules on every cycle.
module tb_fifo_pkt_serializer;

  localparam int unsigned DW  = 24;
  localparam int unsigned WPP = 2;
  localparam logic [7:0]  SYNC = 8'hA5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          fifo_rd_en;
  logic          fifo_rd_empty = 1'b1;
  logic [DW-1:0] fifo_rd_data = '0;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready = 1'b0;
  logic [7:0]    pkt_seq;
  logic          busy;

  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;

  logic [DW-1:0] fifo_q[$];
  logic [7:0]    exp_q[$];
  logic [7:0]    got_q[$];

  int total = 0;
  int bad = 0;
  int rd_pulses = 0;
  int rdy_mode = 0;
  int stall_left = 0;
  int stall_seen = 0;

  logic       prev_rst = 1'b1;
  logic       prev_valid = 1'b0;
  logic       prev_ready = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic       prev_rd_en = 1'b0;
  logic       prev_busy = 1'b0;
  logic       prev_empty = 1'b1;

  fifo_pkt_serializer #(
    .DATA_WIDTH   (DW),
    .WORDS_PER_PKT(WPP),
    .SYNC_BYTE    (SYNC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_empty(fifo_rd_empty),
    .fifo_rd_data (fifo_rd_data),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .pkt_seq      (pkt_seq),
    .busy         (busy)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- FIFO read-side model ----------------
  always @(posedge clk) begin
    if (fifo_rd_en && fifo_q.size() > 0) fifo_rd_data <= fifo_q.pop_front();
    if (wr_en) fifo_q.push_back(wr_data);
    fifo_rd_empty <= (fifo_q.size() == 0);
  end

  // ---------------- tx_ready driver ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 0) begin
        tx_ready = 1'b1;
      end else if (stall_left > 0 && tx_valid && tx_data == 8'h34) begin
        tx_ready = 1'b0;
        stall_left--;
        stall_seen++;
      end else begin
        tx_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    wr_en   = 1'b1;
    wr_data = w;
    tick(1);
    wr_en   = 1'b0;
  endtask

  // Framing rule: sync byte, sequence number, then each word MSB byte first.
  task automatic expect_packet(input logic [7:0] seq, input logic [DW-1:0] w0,
                               input logic [DW-1:0] w1);
    logic [DW-1:0] words [2];
    words[0] = w0;
    words[1] = w1;
    exp_q.push_back(SYNC);
    exp_q.push_back(seq);
    for (int w = 0; w < 2; w++)
      for (int b = DW / 8 - 1; b >= 0; b--)
        exp_q.push_back(8'((words[w] >> (8 * b)) & 24'hFF));
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0 || !fifo_rd_empty) && n < budget) begin
      tick(1);
      n++;
    end
    check({name, "_done_in_budget"}, 32'(n < budget), 32'd1);
  endtask

  function automatic logic [DW-1:0] word_of(input int p, input int w);
    return {8'(p), 8'(w + 8'h5A), ~8'(p)};
  endfunction

  // ---------------- scoreboard / protocol monitor ----------------
  always @(negedge clk) begin
    if (!rst && !prev_rst) begin
      check("rd_en_while_empty", 32'(fifo_rd_en && fifo_rd_empty), 32'd0);
      check("rd_en_back_to_back", 32'(fifo_rd_en && prev_rd_en), 32'd0);
      if (prev_valid && !prev_ready) begin
        check("stall_valid_held", 32'(tx_valid), 32'd1);
        check("stall_data_held", 32'(tx_data), 32'(prev_data));
      end
      if (!prev_busy && !prev_empty)
        check("hdr_one_cycle_after_nonempty", {22'd0, tx_valid, busy, tx_data},
              {22'd0, 1'b1, 1'b1, SYNC});
      if (tx_valid && tx_ready) begin
        got_q.push_back(tx_data);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_byte: got=%0h expected=none", tx_data);
        end else begin
          check("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
        end
      end
      if (fifo_rd_en) rd_pulses <= rd_pulses + 1;
    end
    prev_rst   <= rst;
    prev_valid <= tx_valid;
    prev_ready <= tx_ready;
    prev_data  <= tx_data;
    prev_rd_en <= fifo_rd_en;
    prev_busy  <= busy;
    prev_empty <= fifo_rd_empty;
  end

  // ---------------- directed tests ----------------
  logic [7:0] lit1 [8];
  logic [7:0] lit3 [8];

  initial begin
    int pulses0;
    int n;
    lit1 = '{8'hA5, 8'h00, 8'h12, 8'h34, 8'h56, 8'hAB, 8'hCD, 8'hEF};
    lit3 = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'h01, 8'h00, 8'hBE, 8'hEF};

    // reset values
    rst = 1'b1;
    tick(3);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_pkt_seq", 32'(pkt_seq), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    rst = 1'b0;
    tick(2);

    // 1: basic packet, tx_ready=1
    rdy_mode = 0;
    got_q.delete();
    pulses0 = rd_pulses;
    expect_packet(8'h00, 24'h123456, 24'hABCDEF);
    push_word(24'h123456);
    push_word(24'hABCDEF);
    wait_idle(200, "t1");
    check("t1_pkt_seq", 32'(pkt_seq), 32'd1);
    check("t1_busy", 32'(busy), 32'd0);
    check("t1_pops", 32'(rd_pulses - pulses0), 32'd2);
    check("t1_len", 32'(got_q.size()), 32'd8);
    for (int i = 0; i < 8; i++)
      if (i < got_q.size()) check("t1_literal_byte", 32'(got_q[i]), 32'(lit1[i]));

    // 2: random tx_ready with a 5-cycle stall on 0x34
    rdy_mode   = 1;
    stall_left = 5;
    stall_seen = 0;
    expect_packet(8'h01, 24'h123456, 24'hABCDEF);
    push_word(24'h123456);
    push_word(24'hABCDEF);
    wait_idle(500, "t2");
    rdy_mode = 0;
    tick(1);
    check("t2_stall_cycles", 32'(stall_seen), 32'd5);
    check("t2_pkt_seq", 32'(pkt_seq), 32'd2);

    // 3: mid-packet underflow
    got_q.delete();
    expect_packet(8'h02, 24'h000001, 24'h00BEEF);
    push_word(24'h000001);
    tick(12);
    check("t3_bytes_left", 32'(exp_q.size()), 32'd3);
    for (int i = 0; i < 8; i++) begin
      check("t3_stall_valid", 32'(tx_valid), 32'd0);
      check("t3_stall_rd_en", 32'(fifo_rd_en), 32'd0);
      check("t3_stall_busy", 32'(busy), 32'd1);
      tick(1);
    end
    push_word(24'h00BEEF);
    wait_idle(200, "t3");
    check("t3_len", 32'(got_q.size()), 32'd8);
    for (int i = 0; i < 8; i++)
      if (i < got_q.size()) check("t3_literal_byte", 32'(got_q[i]), 32'(lit3[i]));
    check("t3_pkt_seq", 32'(pkt_seq), 32'd3);

    // 4: 257 packets, sequence wraps 0xFF -> 0x00
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(1);
    pulses0 = rd_pulses;
    for (int p = 0; p < 257; p++) expect_packet(8'(p), word_of(p, 0), word_of(p, 1));
    for (int p = 0; p < 257; p++) begin
      push_word(word_of(p, 0));
      push_word(word_of(p, 1));
    end
    wait_idle(8000, "t4");
    check("t4_pkt_seq_wrapped", 32'(pkt_seq), 32'd1);
    check("t4_pops", 32'(rd_pulses - pulses0), 32'd514);

    // 5: reset during byte 2 of word 0
    expect_packet(8'h01, 24'h445566, 24'hAABBCC);
    push_word(24'h445566);
    push_word(24'hAABBCC);
    n = 0;
    while (!(tx_valid && tx_data == 8'h66) && n < 100) begin
      tick(1);
      n++;
    end
    check("t5_reached_byte2", 32'(n < 100), 32'd1);
    rst = 1'b1;
    exp_q.delete();
    tick(1);
    rst = 1'b0;
    check("t5_rst_tx_valid", 32'(tx_valid), 32'd0);
    check("t5_rst_pkt_seq", 32'(pkt_seq), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    // Word 0x445566 was consumed and is lost; 0xAABBCC is still queued.
    expect_packet(8'h00, 24'hAABBCC, 24'h778899);
    push_word(24'h778899);
    wait_idle(200, "t5");
    check("t5_pkt_seq", 32'(pkt_seq), 32'd1);

    // 6: empty FIFO after reset, nothing happens
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      check("t6_rd_en_low", 32'(fifo_rd_en), 32'd0);
      check("t6_tx_valid_low", 32'(tx_valid), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_pkt_serializer.md
Name: fifo_pkt_serializer

Overview:
- Read-side consumer of the 24-bit sample async FIFO, running in the read clock domain.
- Pops words and frames them into packets: sync byte, 8-bit sequence number, then WORDS_PER_PKT words sent MSB byte first.
- Emits the frames as an 8-bit valid/ready byte stream toward the UART/host link transmitter.

Parameters:
DATA_WIDTH, 24, FIFO word width; must be a multiple of 8 (BYTES_PER_WORD = DATA_WIDTH/8).
WORDS_PER_PKT, 16, words per packet; must be at least 1; counter width is clog2(WORDS_PER_PKT), minimum 1.
SYNC_BYTE, 8'hA5, first byte of every packet.

Ports:
clk  input  1  read-domain clock, same as the FIFO rd_clk
rst  input  1  synchronous, active-high reset
fifo_rd_en  output  1  pop request to the FIFO
fifo_rd_empty  input  1  FIFO empty flag
fifo_rd_data  input  DATA_WIDTH  FIFO read data, valid one cycle after an accepted pop
tx_data  output  8  byte to the transmitter
tx_valid  output  1  tx_data is valid
tx_ready  input  1  transmitter accepts the byte
pkt_seq  output  8  sequence number of the packet currently or next being sent
busy  output  1  high in every state except IDLE

Behaviour:
- Clocking/reset: one clock; reset is synchronous and active-high.
- Reset values: state IDLE; tx_valid=0; tx_data=0; pkt_seq=0; word counter=0; byte counter=0; busy=0; fifo_rd_en=0.
- States: IDLE, HDR, SEQ, FETCH, LATCH, SEND.
- IDLE: wait for fifo_rd_empty=0, then go to HDR. No header is emitted until at least one word is present.
- HDR: tx_data=SYNC_BYTE and tx_valid=1. On tx_valid&&tx_ready, go to SEQ.
- SEQ: tx_data=pkt_seq. On handshake, go to FETCH.
- FETCH: tx_valid=0; fifo_rd_en = (state==FETCH) && !fifo_rd_empty, combinational. When fifo_rd_en=1, go to LATCH. While empty, stall here indefinitely with no timeout.
- LATCH: capture fifo_rd_data into the word shift register, set byte counter=0, go to SEND. fifo_rd_en=0.
- SEND: tx_data = shift_reg[DATA_WIDTH-1 -: 8], tx_valid=1. On each handshake, shift left by 8 and increment the byte counter.
  - After byte BYTES_PER_WORD-1, if the word counter is WORDS_PER_PKT-1: clear the word counter, increment pkt_seq mod 256 (255->0), go to IDLE.
  - Otherwise increment the word counter and go to FETCH.
- Handshake rules:
  - tx_data must be stable while tx_valid=1 and tx_ready=0.
  - tx_valid never drops without a handshake.
  - tx_ready has no effect when tx_valid=0.
  - tx_valid and tx_data are registered outputs; the byte after a handshake is presented from the next cycle.
- Pop rules:
  - At most one pop per word; fifo_rd_en is never high in two consecutive cycles.
  - fifo_rd_en is never high while fifo_rd_empty=1.
- Latency, from the cycle fifo_rd_empty falls in IDLE:
  - header tx_valid high 1 cycle later;
  - first data byte valid 2 cycles after the SEQ handshake (FETCH, LATCH), given a non-empty FIFO.
- Throughput with tx_ready=1: BYTES_PER_WORD+2 cycles per word.
- Mid-packet underflow: the packet is not aborted; framing resumes when data arrives.
- Reset during a packet: the partial packet is dropped, pkt_seq returns to 0, and any word already popped is lost.
- Simultaneous rst and handshake: rst wins.

Decomposition:
- Package fifo_pkt_pkg holds:
  - the state enum (IDLE, HDR, SEQ, FETCH, LATCH, SEND);
  - the default SYNC_BYTE constant;
  - the BYTES_PER_WORD derivation function.
- No sub-module; single FSM with a datapath shift register.

Test Plan:
- WORDS_PER_PKT=2; FIFO holds 0x123456, 0xABCDEF; tx_ready=1 -> bytes A5 00 12 34 56 AB CD EF. pkt_seq=1 after the last byte. Exactly 2 fifo_rd_en pulses. Returns to IDLE with busy=0.
- Same data with tx_ready toggling randomly and low for 5 cycles on byte 0x34 -> tx_data holds 0x34 with tx_valid=1 throughout the stall; byte order unchanged.
- Only 0x000001 present; second word written 20 cycles later -> after A5 00 00 00 01, FETCH stalls with tx_valid=0 and fifo_rd_en=0. Resumes with the second word's 3 bytes, no duplicate header.
- Send 257 packets -> sequence bytes 00..FF then 00. Every packet starts with A5.
- rst asserted for 1 cycle during byte 2 of word 0 -> next cycle tx_valid=0, pkt_seq=0, busy=0. Next packet starts A5 00.
- Empty FIFO throughout 100 cycles after reset -> fifo_rd_en and tx_valid stay 0 every cycle.
